// File: rtl/cache_way_ctrl_pkg.sv
// cache_ctrl_pkg: shared widths, controller states and address field helpers
package cache_ctrl_pkg;
  localparam int s_offset = 5;
  localparam int s_index = 3;
  localparam int s_tag = 32 - s_offset - s_index;
  localparam int s_mask = 2**s_offset;
  localparam int s_line = 8*s_mask;
  typedef enum logic [2:0] {IDLE, READ_ARR, COMPARE, WRITEBACK, ALLOCATE} state_t;
  function automatic logic [s_tag-1:0] addr_tag(input logic [31:0] a);
    return a[31 -: s_tag];
  endfunction
  function automatic logic [s_index-1:0] addr_idx(input logic [31:0] a);
    return a[s_offset +: s_index];
  endfunction
  function automatic logic [s_offset-3:0] addr_word(input logic [31:0] a);
    return a[s_offset-1:2];
  endfunction
  function automatic logic [31:0] line_addr(input logic [s_tag-1:0] t, input logic [s_index-1:0] i);
    return {t, i, {s_offset{1'b0}}};
  endfunction
endpackage

// File: rtl/cache_way_ctrl_if.sv
// cache_way_ctrl_if: CPU word request bus
// master drives address/read/write/byte_enable/wdata; slave returns rdata and the resp pulse
interface cache_way_ctrl_if;
  logic [31:0] mem_address;
  logic mem_read;
  logic mem_write;
  logic [3:0] mem_byte_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic mem_resp;
  modport master(output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata, input mem_rdata, mem_resp);
  modport slave(input mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata, output mem_rdata, mem_resp);
endinterface

// File: rtl/cache_line_adapter.sv
// cache_line_adapter: word select, byte mask build and write-word replication
// in: line, word, byte_enable, wdata; out: rdata (selected word), mask (way byte mask), wline (replicated word)
module cache_line_adapter import cache_ctrl_pkg::*; (
  input logic [s_line-1:0] line,
  input logic [s_offset-3:0] word,
  input logic [3:0] byte_enable,
  input logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [s_mask-1:0] mask,
  output logic [s_line-1:0] wline
);
  assign rdata = line[32*word +: 32];
  assign mask = s_mask'(byte_enable) << (4*word);
  assign wline = {(s_line/32){wdata}};
endmodule

// File: rtl/cache_way_ctrl.sv
// cache_way_ctrl: direct-mapped write-back cache controller around one way block
// ports: clk, rst (async active-low), cpu (word request bus), pmem_* (line memory port),
// ld_*/valid_in/dirty_in/tag_in/idx/write_en/data_in to the way, valid_out/dirty_out/tag_out/data_out from it
module cache_way_ctrl import cache_ctrl_pkg::*; (
  input logic clk,
  input logic rst,
  cache_way_ctrl_if.slave cpu,
  output logic [31:0] pmem_address,
  output logic pmem_read,
  output logic pmem_write,
  output logic [s_line-1:0] pmem_wdata,
  input logic [s_line-1:0] pmem_rdata,
  input logic pmem_resp,
  output logic ld_valid,
  output logic valid_in,
  output logic ld_dirty,
  output logic dirty_in,
  output logic ld_tag,
  output logic [s_tag-1:0] tag_in,
  output logic [s_index-1:0] idx,
  output logic [s_mask-1:0] write_en,
  output logic [s_line-1:0] data_in,
  input logic valid_out,
  input logic dirty_out,
  input logic [s_tag-1:0] tag_out,
  input logic [s_line-1:0] data_out
);
  state_t state, state_n;
  logic [s_tag-1:0] tag;
  logic [s_index-1:0] set;
  logic [31:0] rd_word;
  logic [s_mask-1:0] wr_mask;
  logic [s_line-1:0] wr_line;
  logic hit;
  assign tag = addr_tag(cpu.mem_address);
  assign set = addr_idx(cpu.mem_address);
  // idx is the only output not derived from state, so gate it to keep reset outputs all-zero
  assign idx = rst ? set : '0;
  assign hit = valid_out && tag_out == tag;
  cache_line_adapter u_adapter (
    .line(data_out),
    .word(addr_word(cpu.mem_address)),
    .byte_enable(cpu.mem_byte_enable),
    .wdata(cpu.mem_wdata),
    .rdata(rd_word),
    .mask(wr_mask),
    .wline(wr_line)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    cpu.mem_rdata = '0;
    cpu.mem_resp = 1'b0;
    pmem_address = '0;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    pmem_wdata = '0;
    ld_valid = 1'b0;
    valid_in = 1'b0;
    ld_dirty = 1'b0;
    dirty_in = 1'b0;
    ld_tag = 1'b0;
    tag_in = '0;
    write_en = '0;
    data_in = '0;
    case (state)
      IDLE: state_n = (cpu.mem_read || cpu.mem_write) ? READ_ARR : IDLE;
      READ_ARR: state_n = COMPARE;
      COMPARE: begin
        state_n = hit ? IDLE : (valid_out && dirty_out) ? WRITEBACK : ALLOCATE;
        cpu.mem_resp = hit;
        // write wins when read and write are both raised
        if (hit && cpu.mem_write) begin
          write_en = wr_mask;
          data_in = wr_line;
          ld_dirty = 1'b1;
          dirty_in = 1'b1;
        end else if (hit) cpu.mem_rdata = rd_word;
      end
      WRITEBACK: begin
        pmem_write = 1'b1;
        pmem_address = line_addr(tag_out, set);
        pmem_wdata = data_out;
        state_n = pmem_resp ? ALLOCATE : WRITEBACK;
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        pmem_address = line_addr(tag, set);
        if (pmem_resp) begin
          write_en = '1;
          data_in = pmem_rdata;
          ld_tag = 1'b1;
          tag_in = tag;
          ld_valid = 1'b1;
          valid_in = 1'b1;
          ld_dirty = 1'b1;
          state_n = READ_ARR;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_way_ctrl.sv
// tb_cache_way_ctrl: randomized bench against a flat-memory cache reference model
module tb_cache_way_ctrl;
  import cache_ctrl_pkg::*;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;
  cache_way_ctrl_if cpu();
  logic [31:0] pmem_address;
  logic pmem_read, pmem_write, pmem_resp;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic ld_valid, valid_in, ld_dirty, dirty_in, ld_tag;
  logic [23:0] tag_in;
  logic [2:0] idx;
  logic [31:0] write_en;
  logic [255:0] data_in;
  logic valid_out, dirty_out;
  logic [23:0] tag_out;
  logic [255:0] data_out;
  cache_way_ctrl dut (
    .clk(clk), .rst(rst), .cpu(cpu),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .ld_valid(ld_valid), .valid_in(valid_in), .ld_dirty(ld_dirty), .dirty_in(dirty_in),
    .ld_tag(ld_tag), .tag_in(tag_in), .idx(idx), .write_en(write_en), .data_in(data_in),
    .valid_out(valid_out), .dirty_out(dirty_out), .tag_out(tag_out), .data_out(data_out)
  );
  int n_chk = 0;
  int n_pass = 0;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  // way storage block: registered index, outputs show the line addressed last cycle
  logic w_valid[8], w_dirty[8];
  logic [23:0] w_tag[8];
  logic [255:0] w_data[8];
  logic [2:0] idx_q;
  logic way_clr = 1;
  function automatic logic [255:0] merge(input logic [255:0] old, input logic [255:0] nw, input logic [31:0] m);
    logic [255:0] r = old;
    for (int b = 0; b < 32; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction
  always @(posedge clk) begin
    if (way_clr) begin
      for (int k = 0; k < 8; k++) begin
        w_valid[k] <= 0;
        w_dirty[k] <= 0;
        w_tag[k] <= '0;
        w_data[k] <= '0;
      end
      idx_q <= '0;
    end else begin
      if (ld_valid) w_valid[idx] <= valid_in;
      if (ld_dirty) w_dirty[idx] <= dirty_in;
      if (ld_tag) w_tag[idx] <= tag_in;
      w_data[idx] <= merge(w_data[idx], data_in, write_en);
      idx_q <= idx;
    end
  end
  assign valid_out = w_valid[idx_q];
  assign dirty_out = w_dirty[idx_q];
  assign tag_out = w_tag[idx_q];
  assign data_out = w_data[idx_q];
  // reference: truth holds the architecturally current line for every address, backing is physical memory
  logic [255:0] truth[64], backing[64];
  logic m_valid[8], m_dirty[8];
  logic [2:0] m_tag[8];
  int wb_lat = 3, al_lat = 4, cnt = 0, n_rd = 0, n_wr = 0;
  logic [31:0] exp_wb_addr, exp_al_addr;
  logic [255:0] exp_wb_line;
  logic [23:0] exp_tag;
  always @(negedge clk) begin
    if (!rst) begin
      cnt = 0;
      pmem_resp = 0;
    end else begin
      pmem_resp = 0;
      if (pmem_read || pmem_write) begin
        cnt++;
        if (cnt == (pmem_write ? wb_lat : al_lat)) begin
          cnt = 0;
          pmem_resp = 1;
          if (pmem_write) begin
            chk("wb_addr", pmem_address, exp_wb_addr);
            chk("wb_line", pmem_wdata, exp_wb_line);
            backing[pmem_address[10:5]] = pmem_wdata;
            n_wr++;
          end else begin
            chk("al_addr", pmem_address, exp_al_addr);
            pmem_rdata = backing[pmem_address[10:5]];
            n_rd++;
            #1;
            chk("fill_we", write_en, {32{1'b1}});
            chk("fill_ld", {ld_tag, ld_valid, valid_in, ld_dirty, dirty_in}, 5'b11110);
            chk("fill_tag", tag_in, exp_tag);
            chk("fill_data", data_in, pmem_rdata);
          end
        end
      end
    end
  end
  task automatic do_req(input logic [31:0] a, input logic wr, input logic [3:0] be, input logic [31:0] wd, input int wl, input int al);
    int i = int'(a[7:5]);
    int la = int'(a[10:5]);
    int w = int'(a[4:2]);
    int n = 0;
    int r0 = n_rd;
    int w0 = n_wr;
    int exp_n;
    bit miss, dirty;
    miss = !(m_valid[i] && m_tag[i] == a[10:8]);
    dirty = miss && m_valid[i] && m_dirty[i];
    exp_wb_addr = {21'b0, m_tag[i], a[7:5], 5'b0};
    exp_wb_line = truth[{m_tag[i], a[7:5]}];
    exp_al_addr = {a[31:5], 5'b0};
    exp_tag = a[31:8];
    wb_lat = wl;
    al_lat = al;
    exp_n = 2 + (miss ? 2 + al : 0) + (dirty ? wl : 0);
    @(negedge clk);
    cpu.mem_address = a;
    cpu.mem_write = wr;
    cpu.mem_read = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    cpu.mem_byte_enable = be;
    cpu.mem_wdata = wd;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!cpu.mem_resp && n < 300);
    chk("latency", n, exp_n);
    if (cpu.mem_resp) begin
      if (wr) begin
        chk("wr_mask", write_en, 32'(be) << (4*w));
        chk("wr_data", data_in, {8{wd}});
        chk("wr_dirty", {ld_dirty, dirty_in, ld_tag, ld_valid}, 4'b1100);
        for (int b = 0; b < 4; b++) if (be[b]) truth[la][32*w + 8*b +: 8] = wd[8*b +: 8];
      end else chk("rdata", cpu.mem_rdata, truth[la][32*w +: 32]);
    end
    chk("pmem_rd", n_rd - r0, int'(miss));
    chk("pmem_wr", n_wr - w0, int'(dirty));
    if (miss) begin
      m_valid[i] = 1;
      m_tag[i] = a[10:8];
      m_dirty[i] = 0;
    end
    if (wr) m_dirty[i] = 1;
    @(posedge clk);
    #1;
    cpu.mem_read = 0;
    cpu.mem_write = 0;
  endtask
  initial begin
    for (int k = 0; k < 64; k++)
      for (int j = 0; j < 8; j++) backing[k][32*j +: 32] = k * 32'h01000193 + j * 32'h9E3779B9 + 32'h5A5A0000;
    backing[2][64 +: 32] = 32'hCAFEF00D;
    truth = backing;
    for (int k = 0; k < 8; k++) begin
      m_valid[k] = 0;
      m_dirty[k] = 0;
      m_tag[k] = '0;
    end
    pmem_rdata = '0;
    pmem_resp = 0;
    cpu.mem_address = 32'h40;
    cpu.mem_read = 1;
    cpu.mem_write = 0;
    cpu.mem_byte_enable = '0;
    cpu.mem_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {cpu.mem_resp, pmem_read, pmem_write, ld_valid, valid_in, ld_dirty, dirty_in, ld_tag}, 8'h0);
    chk("rst_we", write_en, 0);
    chk("rst_din", data_in, 0);
    chk("rst_paddr", pmem_address, 0);
    chk("rst_pwdata", pmem_wdata, 0);
    chk("rst_idx", idx, 0);
    chk("rst_rdata", cpu.mem_rdata, 0);
    chk("rst_tag_in", tag_in, 0);
    cpu.mem_read = 0;
    way_clr = 0;
    rst = 1;
    do_req(32'h40, 0, 4'h0, 0, 3, 4);
    do_req(32'h48, 0, 4'h0, 0, 3, 4);
    chk("cafe", cpu.mem_rdata, 0);
    chk("cafe_model", truth[2][64 +: 32], 32'hCAFEF00D);
    do_req(32'h44, 1, 4'b0011, 32'h12345678, 3, 4);
    begin
      int n = 0;
      int w0 = n_wr;
      wb_lat = 50;
      @(negedge clk);
      cpu.mem_address = 32'h140;
      cpu.mem_read = 1;
      while (!pmem_write && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("mid_wb_seen", {pmem_write, pmem_address}, {1'b1, 32'h40});
      @(negedge clk);
      #2;
      rst = 0;
      #1;
      chk("mid_rst_pmem", {pmem_read, pmem_write, pmem_address}, 0);
      chk("mid_rst_ld", {ld_valid, ld_dirty, ld_tag, write_en}, 0);
      cpu.mem_read = 0;
      repeat (2) @(negedge clk);
      rst = 1;
      @(posedge clk);
      #1;
      chk("mid_rst_idle", {pmem_read, pmem_write, cpu.mem_resp, n_wr - w0}, 0);
    end
    do_req(32'h140, 0, 4'h0, 0, 2, 3);
    for (int t = 0; t < 200; t++)
      do_req({21'b0, 3'($urandom), 3'($urandom), 3'($urandom), 2'b0}, 1'($urandom), 4'($urandom),
             $urandom, $urandom_range(1, 4), $urandom_range(1, 4));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
